// File: rtl/lookup_stage.sv
// One tree level of the pipelined lookup engine: reads the node addressed by the
// incoming pointer, selects the child pointer and best-so-far result, forwards to the next level.
module lookup_stage #(
  parameter int unsigned STAGE_ID  = 0,
  parameter int unsigned KEY       = 32,
  parameter int unsigned ADDR      = 10,
  parameter int unsigned RESULT    = 16,
  parameter int unsigned DATA      = 72,
  parameter int unsigned STAT_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [KEY-1:0]       in_key,
  input  logic [ADDR-1:0]      in_ptr,
  input  logic [RESULT-1:0]    in_result,
  input  logic                 in_hit,
  input  logic                 in_done,
  output logic [ADDR-1:0]      mem_addr,
  input  logic [DATA-1:0]      mem_rdata,
  output logic                 out_valid,
  output logic [KEY-1:0]       out_key,
  output logic [ADDR-1:0]      out_ptr,
  output logic [RESULT-1:0]    out_result,
  output logic                 out_hit,
  output logic                 out_done,
  output logic [STAT_BITS-1:0] stat_lookups,
  output logic [STAT_BITS-1:0] stat_leaves
);

  // Node word layout, LSB first
  localparam int unsigned LEFT_LSB  = KEY;
  localparam int unsigned RIGHT_LSB = KEY + ADDR;
  localparam int unsigned RES_LSB   = KEY + 2 * ADDR;
  localparam int unsigned RV_BIT    = RES_LSB + RESULT;
  localparam int unsigned LEAF_BIT  = RV_BIT + 1;
  localparam int unsigned USED      = LEAF_BIT + 1;
  localparam int unsigned unused_stage_id = STAGE_ID;

  if (DATA < USED) begin : g_data_too_narrow
    $error("lookup_stage %0d: DATA=%0d narrower than node word %0d", STAGE_ID, DATA, USED);
  end

  if (DATA > USED) begin : g_spare_bits
    logic unused_spare;
    assign unused_spare = ^mem_rdata[DATA-1:USED];
  end

  logic [KEY-1:0]    node_thresh;
  logic [ADDR-1:0]   node_left;
  logic [ADDR-1:0]   node_right;
  logic [RESULT-1:0] node_result;
  logic              node_res_valid;
  logic              node_leaf;

  assign node_thresh    = mem_rdata[KEY-1:0];
  assign node_left      = mem_rdata[LEFT_LSB +: ADDR];
  assign node_right     = mem_rdata[RIGHT_LSB +: ADDR];
  assign node_result    = mem_rdata[RES_LSB +: RESULT];
  assign node_res_valid = mem_rdata[RV_BIT];
  assign node_leaf      = mem_rdata[LEAF_BIT];

  // BRAM read issued straight from the incoming pointer, valid or not
  assign mem_addr = in_ptr;

  logic                 s1_valid_q;
  logic [KEY-1:0]       s1_key_q;
  logic [ADDR-1:0]      s1_ptr_q;
  logic [RESULT-1:0]    s1_result_q;
  logic                 s1_hit_q;
  logic                 s1_done_q;

  logic                 out_valid_q,  out_valid_d;
  logic [KEY-1:0]       out_key_q,    out_key_d;
  logic [ADDR-1:0]      out_ptr_q,    out_ptr_d;
  logic [RESULT-1:0]    out_result_q, out_result_d;
  logic                 out_hit_q,    out_hit_d;
  logic                 out_done_q,   out_done_d;
  logic [STAT_BITS-1:0] lookups_q,    lookups_d;
  logic [STAT_BITS-1:0] leaves_q,     leaves_d;

  // Stage 1: capture the request while the node word is being read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_key_q    <= '0;
      s1_ptr_q    <= '0;
      s1_result_q <= '0;
      s1_hit_q    <= 1'b0;
      s1_done_q   <= 1'b0;
    end else begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_key_q    <= in_key;
        s1_ptr_q    <= in_ptr;
        s1_result_q <= in_result;
        s1_hit_q    <= in_hit;
        s1_done_q   <= in_done;
      end
    end
  end

  // Stage 2 decision: payload holds across bubbles, counters saturate
  always_comb begin
    out_valid_d  = s1_valid_q;
    out_key_d    = out_key_q;
    out_ptr_d    = out_ptr_q;
    out_result_d = out_result_q;
    out_hit_d    = out_hit_q;
    out_done_d   = out_done_q;
    lookups_d    = lookups_q;
    leaves_d     = leaves_q;
    if (s1_valid_q) begin
      out_key_d    = s1_key_q;
      out_ptr_d    = s1_ptr_q;
      out_result_d = s1_result_q;
      out_hit_d    = s1_hit_q;
      out_done_d   = s1_done_q;
      if (!s1_done_q) begin
        if (!(&lookups_q)) lookups_d = lookups_q + STAT_BITS'(1);
        if (node_res_valid) begin
          out_result_d = node_result;
          out_hit_d    = 1'b1;
        end
        if (node_leaf) begin
          out_done_d = 1'b1;
          if (!(&leaves_q)) leaves_d = leaves_q + STAT_BITS'(1);
        end else begin
          out_done_d = 1'b0;
          out_ptr_d  = (s1_key_q >= node_thresh) ? node_right : node_left;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_key_q    <= '0;
      out_ptr_q    <= '0;
      out_result_q <= '0;
      out_hit_q    <= 1'b0;
      out_done_q   <= 1'b0;
      lookups_q    <= '0;
      leaves_q     <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_key_q    <= out_key_d;
      out_ptr_q    <= out_ptr_d;
      out_result_q <= out_result_d;
      out_hit_q    <= out_hit_d;
      out_done_q   <= out_done_d;
      lookups_q    <= lookups_d;
      leaves_q     <= leaves_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_key      = out_key_q;
  assign out_ptr      = out_ptr_q;
  assign out_result   = out_result_q;
  assign out_hit      = out_hit_q;
  assign out_done     = out_done_q;
  assign stat_lookups = lookups_q;
  assign stat_leaves  = leaves_q;

endmodule
